// File: rtl/key_event_queue.sv
// Key event queue: captures one-cycle key strobes into pending bits, arbitrates them into an ordered FIFO.
// Define KEY_EVENT_TIMESTAMP_EN to add a per-event timestamp (event_time port).
module key_event_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8,
    parameter int TS_W  = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [3:0]               keys_pulse,
    output logic                     event_valid,
    input  logic                     event_ready,
    output logic [1:0]               event_key,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_count,
    input  logic                     clear_drops
`ifdef KEY_EVENT_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]          event_time
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [3:0]     pending;
    logic [3:0]     clr;
    logic [3:0]     drop;
    logic [2:0]     drop_n;
    logic [1:0]     sel;
    logic           push;
    logic           pop;
    logic           full;
    logic [1:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  count;
    logic [CNT_W+2:0] drop_sum;

    // Fixed-priority arbiter: lowest pending key index wins
    always_comb begin
        sel = 2'd0;
        if (pending[0])      sel = 2'd0;
        else if (pending[1]) sel = 2'd1;
        else if (pending[2]) sel = 2'd2;
        else if (pending[3]) sel = 2'd3;
    end

    assign full        = (count == LW'(DEPTH));
    assign push        = (|pending) && !full;
    assign event_valid = (count != '0);
    assign pop         = event_valid && event_ready;
    assign clr         = push ? (4'b0001 << sel) : 4'b0000;
    assign drop        = keys_pulse & pending & ~clr;
    assign drop_n      = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
    assign drop_sum    = (CNT_W+3)'(drop_count) + (CNT_W+3)'(drop_n);
    assign level       = count;
    assign event_key   = event_valid ? mem[rd_ptr] : 2'd0;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= keys_pulse | (pending & ~clr);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Saturating drop counter; clear wins over a same-cycle increment
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (clear_drops) begin
            drop_count <= '0;
        end else if (drop_sum > (CNT_W+3)'({CNT_W{1'b1}})) begin
            drop_count <= {CNT_W{1'b1}};
        end else begin
            drop_count <= drop_sum[CNT_W-1:0];
        end
    end

`ifdef KEY_EVENT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_counter;
    logic [TS_W-1:0] pending_ts [4];
    logic [TS_W-1:0] mem_ts [DEPTH];

    // A stamp is taken only when a strobe starts a new event, never on a coalesced one
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            ts_counter <= '0;
            for (int k = 0; k < 4; k++) pending_ts[k] <= '0;
        end else begin
            ts_counter <= ts_counter + 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (keys_pulse[k] && (!pending[k] || clr[k])) pending_ts[k] <= ts_counter;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem[wr_ptr]    <= sel;
            mem_ts[wr_ptr] <= pending_ts[sel];
        end
    end

    assign event_time = event_valid ? mem_ts[rd_ptr] : '0;
`else
    always_ff @(posedge CLOCK_50) begin
        if (push) mem[wr_ptr] <= sel;
    end
`endif

endmodule

// File: tb/tb_key_event_queue.sv
// Directed self-checking bench for key_event_queue: latency, ordering, full FIFO, drop saturation, async reset.
// Timestamp checks compile in when KEY_EVENT_TIMESTAMP_EN is defined.
module tb_key_event_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int TS_W  = 16;

    logic                   CLOCK_50;
    logic                   reset;
    logic [3:0]             keys_pulse;
    logic                   event_valid;
    logic                   event_ready;
    logic [1:0]             event_key;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       drop_count;
    logic                   clear_drops;
`ifdef KEY_EVENT_TIMESTAMP_EN
    logic [TS_W-1:0]        event_time;
    logic [TS_W-1:0]        ts_model;
`endif

    int checks = 0;
    int errors = 0;

    key_event_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .keys_pulse  (keys_pulse),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_key   (event_key),
        .level       (level),
        .drop_count  (drop_count),
        .clear_drops (clear_drops)
`ifdef KEY_EVENT_TIMESTAMP_EN
        ,
        .event_time  (event_time)
`endif
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

`ifdef KEY_EVENT_TIMESTAMP_EN
    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) ts_model <= '0;
        else       ts_model <= ts_model + 1'b1;
    end
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge
    task automatic applyStimulus(input logic [3:0] pulse, input logic ready, input logic clr);
        keys_pulse  = pulse;
        event_ready = ready;
        clear_drops = clr;
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        keys_pulse  = 4'b0000;
        event_ready = 1'b0;
        clear_drops = 1'b0;
        #12;
        reset = 1'b0;
        checkOutput("rst_valid", 32'(event_valid), 0);
        checkOutput("rst_level", 32'(level), 0);
        checkOutput("rst_key", 32'(event_key), 0);
        checkOutput("rst_drops", 32'(drop_count), 0);
        checkOutput("rst_pending", 32'(dut.pending), 0);

        // Single strobe on key 2, two-cycle latency
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("t1_valid_n1", 32'(event_valid), 0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("t1_valid_n2", 32'(event_valid), 1);
        checkOutput("t1_key", 32'(event_key), 2);
        checkOutput("t1_level1", 32'(level), 1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("t1_level0", 32'(level), 0);
        checkOutput("t1_valid0", 32'(event_valid), 0);
        checkOutput("t1_drops", 32'(drop_count), 0);

        // Simultaneous strobes queue in ascending key order
        applyStimulus(4'b1011, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t2_level", 32'(level), 3);
        checkOutput("t2_pending", 32'(dut.pending), 0);
        checkOutput("t2_key_a", 32'(event_key), 0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("t2_key_b", 32'(event_key), 1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("t2_key_c", 32'(event_key), 3);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("t2_level0", 32'(level), 0);
        checkOutput("t2_drops", 32'(drop_count), 0);

        // Fill the FIFO with key 1; the tenth strobe coalesces
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0010, 1'b0, 1'b0);
            applyStimulus(4'b0000, 1'b0, 1'b0);
            applyStimulus(4'b0000, 1'b0, 1'b0);
        end
        checkOutput("t3_level_full", 32'(level), 8);
        checkOutput("t3_pending", 32'(dut.pending), 2);
        checkOutput("t3_drops", 32'(drop_count), 1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("t3_pop_level", 32'(level), 7);
        checkOutput("t3_pop_pending", 32'(dut.pending), 2);
        checkOutput("t3_head_key", 32'(event_key), 1);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t3_refill_level", 32'(level), 8);
        checkOutput("t3_refill_pending", 32'(dut.pending), 0);

        // Drop counter saturation, clear precedence, multi-key drops
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("t4_no_drop", 32'(drop_count), 1);
        for (int i = 0; i < 300; i++) applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("t4_saturate", 32'(drop_count), 255);
        applyStimulus(4'b0010, 1'b0, 1'b1);
        checkOutput("t4_clear", 32'(drop_count), 0);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("t4_after_clear", 32'(drop_count), 1);
        applyStimulus(4'b0111, 1'b0, 1'b0);
        checkOutput("t4_partial_drop", 32'(drop_count), 2);
        checkOutput("t4_pending", 32'(dut.pending), 7);
        applyStimulus(4'b0111, 1'b0, 1'b0);
        checkOutput("t4_triple_drop", 32'(drop_count), 5);

        // Asynchronous reset between edges
        applyStimulus(4'b0000, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("t5_valid", 32'(event_valid), 0);
        checkOutput("t5_level", 32'(level), 0);
        checkOutput("t5_drops", 32'(drop_count), 0);
        checkOutput("t5_pending", 32'(dut.pending), 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        applyStimulus(4'b1000, 1'b1, 1'b0);
        checkOutput("t5_lat_n1", 32'(event_valid), 0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("t5_lat_n2", 32'(event_valid), 1);
        checkOutput("t5_key", 32'(event_key), 3);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("t5_level0", 32'(level), 0);

        // Continuous strobes on key 0 with ready: push and pop balance, no drops
        for (int i = 0; i < 6; i++) applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("t6_level", 32'(level), 1);
        checkOutput("t6_drops", 32'(drop_count), 0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("t6_level_tail", 32'(level), 1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("t6_level0", 32'(level), 0);
        checkOutput("t6_valid0", 32'(event_valid), 0);

`ifdef KEY_EVENT_TIMESTAMP_EN
        // Timestamps follow events; a coalesced repeat keeps the original stamp
        event_ready = 1'b0;
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 200 && ts_model != 16'd100; i++) applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("ts_reach100", 32'(ts_model), 100);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 20 && ts_model != 16'd103; i++) applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("ts_reach103", 32'(ts_model), 103);
        applyStimulus(4'b1110, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("ts_level", 32'(level), 4);
        checkOutput("ts_drops", 32'(drop_count), 1);
        checkOutput("ts_key0", 32'(event_key), 0);
        checkOutput("ts_time0", 32'(event_time), 100);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("ts_key1", 32'(event_key), 1);
        checkOutput("ts_time1", 32'(event_time), 103);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("ts_key2", 32'(event_key), 2);
        checkOutput("ts_time2", 32'(event_time), 103);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("ts_key3", 32'(event_key), 3);
        checkOutput("ts_time3", 32'(event_time), 103);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("ts_level0", 32'(level), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
